// File: rtl/cavlc_blk_seq.sv
// rtl/cavlc_blk_seq.sv - per-4x4-block CAVLC encode sequencer with NC selection
module cavlc_blk_seq #(
  parameter int NUM_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blk_valid,
  output logic       blk_ready,
  input  logic       blk_chroma_dc,
  input  logic [4:0] blk_total_coeff,
  input  logic [1:0] blk_trail_one,
  input  logic [4:0] nA,
  input  logic [4:0] nB,
  input  logic       availA,
  input  logic       availB,
  input  logic       pk_ready,
  output logic [3:0] state,
  output logic [2:0] NC,
  output logic [4:0] TotalCoeff,
  output logic [1:0] TrailOneNum,
  output logic       blk_done
);

  typedef enum logic [3:0] {
    ENC_INIT   = 4'd0,
    ENC_CYCLE0 = 4'd1,
    ENC_CYCLE1 = 4'd2,
    ENC_CYCLE2 = 4'd3,
    ENC_CYCLE3 = 4'd4,
    ENC_CYCLE4 = 4'd5,
    ENC_CYCLE5 = 4'd6,
    ENC_CYCLE6 = 4'd7,
    ENC_CYCLE7 = 4'd8
  } state_t;

  localparam logic [3:0] LAST_CYC = 4'(NUM_CYC);

  state_t     cur;
  state_t     nxt;
  logic       accept;
  logic       done_nxt;
  logic [5:0] nc_val;
  logic [2:0] nc_sel;

  assign blk_ready = (cur == ENC_INIT);
  assign accept    = blk_valid & blk_ready;
  assign state     = cur;

  // Neighbour-based nC; the +1 rounds the average up before halving.
  always_comb begin
    nc_val = 6'd0;
    if (availA && availB)
      nc_val = ({1'b0, nA} + {1'b0, nB} + 6'd1) >> 1;
    else if (availA)
      nc_val = {1'b0, nA};
    else if (availB)
      nc_val = {1'b0, nB};

    nc_sel = 3'd0;
    if (blk_chroma_dc)
      nc_sel = 3'b111;
    else if (nc_val < 6'd2)
      nc_sel = 3'd0;
    else if (nc_val < 6'd4)
      nc_sel = 3'd1;
    else if (nc_val < 6'd8)
      nc_sel = 3'd2;
    else
      nc_sel = 3'd3;
  end

  always_comb begin
    nxt      = cur;
    done_nxt = 1'b0;
    if (cur == ENC_INIT) begin
      if (accept)
        nxt = ENC_CYCLE0;
    end else if (pk_ready) begin
      // Empty blocks only emit coeff_token, so they leave after enc_cycle0.
      if ((cur == ENC_CYCLE0 && TotalCoeff == 5'd0) || cur == state_t'(LAST_CYC)) begin
        nxt      = ENC_INIT;
        done_nxt = 1'b1;
      end else begin
        nxt = state_t'(cur + 4'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cur         <= ENC_INIT;
      NC          <= 3'd0;
      TotalCoeff  <= 5'd0;
      TrailOneNum <= 2'd0;
      blk_done    <= 1'b0;
    end else begin
      cur      <= nxt;
      blk_done <= done_nxt;
      if (accept) begin
        NC          <= nc_sel;
        TotalCoeff  <= blk_total_coeff;
        TrailOneNum <= blk_trail_one;
      end
    end
  end

endmodule

// File: tb/tb_cavlc_blk_seq.sv
// tb/tb_cavlc_blk_seq.sv - scoreboard bench for cavlc_blk_seq
module tb_cavlc_blk_seq;

  localparam int NUM_CYC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       blk_valid = 1'b0;
  logic       blk_ready;
  logic       blk_chroma_dc = 1'b0;
  logic [4:0] blk_total_coeff = '0;
  logic [1:0] blk_trail_one = '0;
  logic [4:0] nA = '0;
  logic [4:0] nB = '0;
  logic       availA = 1'b0;
  logic       availB = 1'b0;
  logic       pk_ready = 1'b1;
  logic [3:0] state;
  logic [2:0] NC;
  logic [4:0] TotalCoeff;
  logic [1:0] TrailOneNum;
  logic       blk_done;

  cavlc_blk_seq #(.NUM_CYC(NUM_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_chroma_dc(blk_chroma_dc), .blk_total_coeff(blk_total_coeff),
    .blk_trail_one(blk_trail_one), .nA(nA), .nB(nB), .availA(availA),
    .availB(availB), .pk_ready(pk_ready), .state(state), .NC(NC),
    .TotalCoeff(TotalCoeff), .TrailOneNum(TrailOneNum), .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nc;
    int tc;
    int t1;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   pk_mode = 0;
  bit   in_blk = 0;
  bit   pend_done = 0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference NC selection straight from the neighbour rules.
  function automatic int ref_nc(input bit ch, input int na, input int nb,
                                input bit aa, input bit ab);
    int n;
    if (ch) return 7;
    if (aa && ab) n = (na + nb + 1) / 2;
    else if (aa) n = na;
    else if (ab) n = nb;
    else n = 0;
    if (n < 2) return 0;
    if (n < 4) return 1;
    if (n < 8) return 2;
    return 3;
  endfunction

  // Called just after a posedge; returns just after the accepting posedge with valid still high.
  task automatic send(input bit ch, input int tc, input int t1, input int na,
                      input int nb, input bit aa, input bit ab);
    int n;
    exp_t e;
    blk_chroma_dc   = ch;
    blk_total_coeff = 5'(tc);
    blk_trail_one   = 2'(t1);
    nA = 5'(na);
    nB = 5'(nb);
    availA = aa;
    availB = ab;
    blk_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!blk_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!blk_ready) begin
      chk("accept_timeout", 0, 1);
      blk_valid = 1'b0;
    end else begin
      e.nc = ref_nc(ch, na, nb, aa, ab);
      e.tc = tc;
      e.t1 = t1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    blk_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    pk_ready = (pk_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: tracks each block from its enc_cycle0 through its blk_done cycle.
  initial begin : monitor
    exp_t cur;
    int   exp_state;
    bit   chk_rst;
    chk_rst = 0;
    exp_state = 0;
    cur.nc = 0; cur.tc = 0; cur.t1 = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        in_blk = 0;
        pend_done = 0;
        chk_rst = 1;
      end else begin
        if (chk_rst) begin
          chk("rst_state", state, 0);
          chk("rst_ready", blk_ready, 1);
          chk("rst_nc", NC, 0);
          chk("rst_tc", TotalCoeff, 0);
          chk("rst_t1", TrailOneNum, 0);
          chk("rst_done", blk_done, 0);
          chk_rst = 0;
        end
        chk("blk_done", blk_done, pend_done);
        if (pend_done) begin
          chk("done_state", state, 0);
          chk("done_nc_hold", NC, cur.nc);
          chk("done_tc_hold", TotalCoeff, cur.tc);
          chk("done_t1_hold", TrailOneNum, cur.t1);
          pend_done = 0;
        end
        if (!in_blk && state != 0) begin
          if (q.size() == 0) begin
            chk("unexpected_block", state, 0);
          end else begin
            cur = q.pop_front();
            chk("start_state", state, 1);
            chk("nc", NC, cur.nc);
            chk("total_coeff", TotalCoeff, cur.tc);
            chk("trail_one", TrailOneNum, cur.t1);
            in_blk = 1;
            exp_state = 1;
          end
        end
        if (in_blk) begin
          chk("seq_state", state, exp_state);
          if (pk_ready) begin
            if ((exp_state == 1 && cur.tc == 0) || exp_state == NUM_CYC) begin
              in_blk = 0;
              pend_done = 1;
            end else begin
              exp_state++;
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    int tc;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    pk_mode = 0;
    send(0, 5, 2, 3, 4, 1, 1);
    send(0, 5, 2, 1, 2, 1, 1);
    send(0, 3, 1, 8, 0, 1, 0);
    send(0, 3, 1, 9, 9, 0, 0);
    send(1, 4, 0, 16, 16, 1, 1);
    send(0, 0, 0, 2, 5, 0, 1);
    send(0, 16, 3, 31, 31, 1, 1);
    idle(12);

    pk_mode = 1;
    send(0, 7, 3, 4, 4, 1, 1);
    send(0, 0, 0, 1, 1, 1, 1);
    idle(30);

    // Mid-block reset abandons the block with no blk_done.
    pk_mode = 0;
    send(0, 5, 2, 6, 6, 1, 1);
    idle(3);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle(3);

    pk_mode = 1;
    for (int i = 0; i < 150; i++) begin
      tc = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 16);
      send($urandom_range(0, 7) == 0, tc,
           $urandom_range(0, (tc < 3) ? tc : 3),
           $urandom_range(0, 16), $urandom_range(0, 16),
           $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    blk_valid = 1'b0;

    n = 0;
    while ((q.size() != 0 || in_blk || pend_done) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size() + int'(in_blk) + int'(pend_done), 0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cavlc_blk_seq.md
Name: cavlc_blk_seq

Overview:
Per-4x4-block sequencer for the CAVLC coefficient-token encoder and the later CAVLC encode stages. It accepts one block descriptor at a time: TotalCoeff, TrailOneNum, block type, and neighbour A/B non-zero counts. It derives the 3-bit NC table selector and drives the shared 4-bit state bus (enc_init, enc_cycle0..enc_cycle7). It stalls on bitstream-packer backpressure and returns a done pulse per block.

Parameters:
NUM_CYC, 8, encode cycles per non-empty block (enc_cycle0..enc_cycle(NUM_CYC-1)); legal range 2..8

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-high reset (asserted = 1 despite the _n suffix), sampled on rising clk
blk_valid  in  1  descriptor valid
blk_ready  out  1  sequencer can accept a descriptor
blk_chroma_dc  in  1  1 = chroma DC block (NC forced to 3'b111)
blk_total_coeff  in  5  TotalCoeff, 0..16
blk_trail_one  in  2  TrailOneNum, 0..3
nA  in  5  left neighbour TotalCoeff
nB  in  5  top neighbour TotalCoeff
availA  in  1  left neighbour available
availB  in  1  top neighbour available
pk_ready  in  1  bitstream packer accepts this cycle's code
state  out  4  encode-cycle bus: 0 = enc_init, 1..8 = enc_cycle0..enc_cycle7
NC  out  3  0: nC<2; 1: 2..3; 2: 4..7; 3: >=8; 7: chroma DC
TotalCoeff  out  5  latched TotalCoeff
TrailOneNum  out  2  latched TrailOneNum
blk_done  out  1  one-cycle pulse when the block completes

Behaviour:
- Reset (rst_n=1 at clk edge): state=enc_init, NC=0, TotalCoeff=0, TrailOneNum=0, blk_done=0, blk_ready=1. Reset overrides all other inputs, including mid-block; any in-flight block is abandoned with no blk_done.
- blk_ready = (state==enc_init), combinational from the state register.
- Accept: blk_valid & blk_ready at a clk edge.
  - Latch TotalCoeff and TrailOneNum from the descriptor.
  - Compute and latch NC.
  - Next state = enc_cycle0. The first encode cycle follows the accept edge (1-cycle latency).
- nC arithmetic, 6-bit internal:
  - both neighbours available: nC = (nA+nB+1)>>1
  - only A available: nC = nA
  - only B available: nC = nB
  - neither: nC = 0
- NC mapping: blk_chroma_dc=1 gives 3'b111 regardless of neighbours; otherwise NC follows the nC thresholds listed under Ports.
- Advance rule: while state is an enc_cycleK, state holds when pk_ready=0 and advances when pk_ready=1.
- Empty block (latched TotalCoeff==0): on a pk_ready=1 edge, enc_cycle0 goes directly to enc_init; only coeff_token is emitted.
- Non-empty block: enc_cycle0 -> enc_cycle1 -> ... -> enc_cycle(NUM_CYC-1) -> enc_init, each step gated by pk_ready.
- blk_done is registered and high for exactly the one cycle after the final advance edge, i.e. the first enc_init cycle.
- Back-to-back blocks: a descriptor may be accepted in that same enc_init cycle. Minimum inter-block gap is therefore 1 idle cycle.
- Latched outputs (NC, TotalCoeff, TrailOneNum) are stable from enc_cycle0 until the next accept; they are not cleared at block end.
- Inputs other than pk_ready are ignored while state != enc_init.
- blk_total_coeff > 16 is illegal. The value is latched unmodified; behaviour is defined only for 0..16.
- blk_trail_one > min(3, TotalCoeff) is illegal and is not checked.
- State encoding must exactly match the values listed for the state port: enc_init=0000, enc_cycle0=0001 ... enc_cycle7=1000.

Test Plan:
1. Reset mid-block: accept a block, hold pk_ready=1 for 3 cycles, assert rst_n for 1 cycle -> state=0, blk_ready=1, NC=0, TotalCoeff=0, TrailOneNum=0, no blk_done.
2. nC table: availA=availB=1, nA=3, nB=4 -> NC=2 (nC=4). nA=1, nB=2 -> NC=1 (nC=2). Only A, nA=8 -> NC=3. Neither available -> NC=0. blk_chroma_dc=1 with nA=nB=16 -> NC=7.
3. Empty block, pk_ready=1: total_coeff=0 -> state sequence 0,1,0, blk_done high on the second 0 cycle, 3 cycles total.
4. Full block: total_coeff=5, trail_one=2, NUM_CYC=8, pk_ready=1 -> state 1..8 on consecutive cycles, then 0 with blk_done. TotalCoeff=5 and TrailOneNum=2 held throughout.
5. Backpressure: pk_ready low for 4 cycles while in enc_cycle2 (state=3) -> state holds at 3 for 4 cycles, then resumes; blk_done arrives 4 cycles later than in test 4.
6. Back-to-back: blk_valid held high with two descriptors -> second accepted in the blk_done cycle, its enc_cycle0 on the next cycle; first block's latched values stay on the outputs until that accept edge.
